// File: rtl/div_const_seq_ctrl.sv
// Sequential divide-by-constant controller: one radix-2^K quotient digit per clock, MSB chunk first.
// Latency: STEPS cycles accept->out_valid (n cycles with DIV_CONST_EARLY_EXIT_EN); result held until out_ready.
module div_const_seq_ctrl #(
    parameter int W       = 64,
    parameter int K       = 3,
    parameter int DIVISOR = 5,
    parameter int RW      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_dividend,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_quotient,
    output logic [RW-1:0] out_remainder,
    output logic          busy
);

    localparam int STEPS = (W + K - 1) / K;
    localparam int PW    = STEPS * K;
    localparam int CW    = $clog2(STEPS + 1);
    localparam int TW    = RW + K;
    localparam logic [TW-1:0] DIV_C = DIVISOR[TW-1:0];

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   dvd;
    logic [W-1:0]    quo;
    logic [RW-1:0]   r;
    logic [CW-1:0]   cnt;

    logic [PW-1:0]   pad;
    logic [PW-1:0]   load_dvd;
    logic [CW-1:0]   load_n;
    logic [TW-1:0]   t;
    logic [K-1:0]    digit;
    logic [RW-1:0]   r_next;
    logic [W-1:0]    quo_next;

    assign pad = PW'(in_dividend);

`ifdef DIV_CONST_EARLY_EXIT_EN
    // Skip leading all-zero chunks: they yield zero digits and keep r at 0.
    always_comb begin
        load_n   = CW'(1);
        load_dvd = pad;
        for (int i = 0; i < STEPS; i++) begin
            if (pad[i*K +: K] != '0) begin
                load_n   = CW'(i + 1);
                load_dvd = pad << ((STEPS - 1 - i) * K);
            end
        end
    end
`else
    assign load_n   = CW'(STEPS);
    assign load_dvd = pad;
`endif

    // r < DIVISOR guarantees the digit fits in K bits.
    always_comb begin
        t        = {r, dvd[PW-1 -: K]};
        digit    = K'(t / DIV_C);
        r_next   = RW'(t % DIV_C);
        quo_next = (quo << K) | W'(digit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            dvd           <= '0;
            quo           <= '0;
            r             <= '0;
            cnt           <= '0;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
            out_quotient  <= '0;
            out_remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd      <= load_dvd;
                        quo      <= '0;
                        r        <= '0;
                        cnt      <= load_n;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    dvd <= dvd << K;
                    quo <= quo_next;
                    r   <= r_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state         <= DONE;
                        out_valid     <= 1'b1;
                        out_quotient  <= quo_next;
                        out_remainder <= r_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_const_seq_ctrl.sv
// Self-checking bench for div_const_seq_ctrl: directed cases plus a random sweep against d/5, d%5.
module tb_div_const_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_dividend;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_quotient;
    logic [2:0]  out_remainder;
    logic        busy;

    int checks = 0;
    int errors = 0;

    div_const_seq_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dividend   (in_dividend),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycles from accept edge to out_valid, derived from the dividend's bit length.
    function automatic int exp_lat(input logic [63:0] d);
`ifdef DIV_CONST_EARLY_EXIT_EN
        int bits;
        bits = 0;
        for (int b = 0; b < 64; b++) if (d[b]) bits = b + 1;
        return (bits == 0) ? 1 : (bits + 2) / 3;
`else
        return 22;
`endif
    endfunction

    // Called just after an edge; counts edges until out_valid rises.
    task automatic wait_result(input logic [63:0] d, input string tag);
        int lat;
        logic [63:0] q;
        logic [63:0] rr;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 100);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(d)));
        q  = out_quotient;
        rr = 64'(out_remainder);
        chk({tag, "_q"}, q, d / 64'd5);
        chk({tag, "_r"}, rr, d % 64'd5);
        chk({tag, "_recon"}, q * 64'd5 + rr, d);
    endtask

    task automatic accept(input logic [63:0] d);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("ready_wait", 64'(in_ready), 64'd1);
        in_valid    = 1'b1;
        in_dividend = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drop_valid", 64'(out_valid), 64'd0);
        chk("back_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input logic [63:0] d, input string tag);
        accept(d);
        wait_result(d, tag);
        release_result();
    endtask

    initial begin
        logic [63:0] d;
        logic [63:0] hq;
        logic [63:0] hr;

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_dividend = '0;
        out_ready   = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_q", out_quotient, 64'd0);
        chk("rst_r", 64'(out_remainder), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // out_ready held high throughout, including while running
        out_ready = 1'b1;
        accept(64'd1000);
        chk("run_no_valid", 64'(out_valid), 64'd0);
        wait_result(64'd1000, "d1000");
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("d1000_drop", 64'(out_valid), 64'd0);

        run_op(64'hFFFF_FFFF_FFFF_FFFF, "dmax");
        chk("dmax_q_const", out_quotient, 64'h3333_3333_3333_3333);
        run_op(64'd123456789, "d123456789");
        chk("d123456789_q_const", out_quotient, 64'd24691357);
        run_op(64'd7, "d7");
        chk("d7_r_const", 64'(out_remainder), 64'd2);
        run_op(64'd0, "d0");
        run_op(64'd10, "d10");

        // Back-pressure in DONE with a second dividend waiting
        accept(64'd123456789);
        wait_result(64'd123456789, "bp");
        hq = out_quotient;
        hr = 64'(out_remainder);
        in_valid    = 1'b1;
        in_dividend = 64'd1000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_q_stable", out_quotient, hq);
            chk("bp_r_stable", 64'(out_remainder), hr);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        chk("bp_release_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_queued_accept", 64'(busy), 64'd1);
        wait_result(64'd1000, "bp_second");
        release_result();

        // Asynchronous reset in the middle of a run
        accept(64'hFFFF_FFFF_FFFF_FFFF);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_q", out_quotient, 64'd0);
        chk("mid_rst_r", 64'(out_remainder), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            chk("mid_no_valid", 64'(out_valid), 64'd0);
        end
        run_op(64'd10, "after_rst");

        // Random sweep over full-width and shortened dividends
        for (int n = 0; n < 300; n++) begin
            d = {$urandom, $urandom};
            d = d >> $urandom_range(0, 63);
            run_op(d, "rand");
            chk("rand_r_lt5", 64'(out_remainder < 3'd5), 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
